// File: rtl/factorial_divider_pkg.sv
// Shared widths, state encoding and constants for the factorial divider.
// The operand widths match the Booth multiplier datapath that produces n!.
package factorial_divider_pkg;

    localparam int DIVIDEND_W = 128;
    localparam int DIVISOR_W  = 64;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = {DIVIDEND_W{1'b1}};

endpackage

// File: rtl/factorial_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// conditionally subtract the divisor, producing one quotient bit.
import factorial_divider_pkg::*;

module factorial_divider_div_step (
    input  logic [DIVISOR_W:0]   partial_rem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   new_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted_s;
    logic [DIVISOR_W:0]   sub_b_s;
    logic [DIVISOR_W+1:0] sum_s;
    logic                 no_borrow_s;

    // Trial subtract as an add of the ones complement with carry-in 1.
    // A set partial_rem MSB means the shifted value already exceeds the
    // divisor, so it forces the subtract regardless of the carry.
    always_comb begin
        shifted_s   = {partial_rem[DIVISOR_W-1:0], next_bit};
        sub_b_s     = ~{1'b0, divisor};
        sum_s       = {1'b0, shifted_s} + {1'b0, sub_b_s} + {{(DIVISOR_W+1){1'b0}}, 1'b1};
        no_borrow_s = sum_s[DIVISOR_W+1] | partial_rem[DIVISOR_W];
        if (no_borrow_s) begin
            new_rem = sum_s[DIVISOR_W:0];
            q_bit   = 1'b1;
        end else begin
            new_rem = shifted_s;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/factorial_divider.sv
// Sequential radix-2 restoring divider: 128-bit dividend / 64-bit divisor,
// one quotient bit per clock, with start/busy/done handshake.
import factorial_divider_pkg::*;

module factorial_divider (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    div_state_t            state_r, state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [DIVISOR_W:0]    prem_r;
    logic [DIVIDEND_W-1:0] dshift_r;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dbz_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  load_s;
    logic                  dbz_load_s;
    logic                  step_s;
    logic [DIVISOR_W:0]    step_rem_s;
    logic                  step_q_s;

    factorial_divider_div_step u_div_step (
        .partial_rem (prem_r),
        .next_bit    (dshift_r[DIVIDEND_W-1]),
        .divisor     (divisor_r),
        .new_rem     (step_rem_s),
        .q_bit       (step_q_s)
    );

    // Next-state and datapath strobes; DONE accepts start just like IDLE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        dbz_load_s   = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor != {DIVISOR_W{1'b0}}) begin
                        state_next_s = CALC;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = DONE;
                        dbz_load_s   = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (cnt_r == CNT_W'(DIVIDEND_W - 1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            prem_r      <= {(DIVISOR_W+1){1'b0}};
            dshift_r    <= {DIVIDEND_W{1'b0}};
            divisor_r   <= {DIVISOR_W{1'b0}};
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CALC);
            done_r  <= (state_next_s == DONE);
            if (load_s) begin
                dshift_r  <= dividend;
                divisor_r <= divisor;
                prem_r    <= {(DIVISOR_W+1){1'b0}};
                cnt_r     <= {CNT_W{1'b0}};
                dbz_r     <= 1'b0;
            end else if (dbz_load_s) begin
                quotient_r  <= DBZ_QUOTIENT;
                remainder_r <= dividend[DIVISOR_W-1:0];
                dbz_r       <= 1'b1;
            end else if (step_s) begin
                prem_r   <= step_rem_s;
                dshift_r <= {dshift_r[DIVIDEND_W-2:0], step_q_s};
                cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (state_next_s == DONE) begin
                    quotient_r  <= {dshift_r[DIVIDEND_W-2:0], step_q_s};
                    remainder_r <= step_rem_s[DIVISOR_W-1:0];
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_factorial_divider.sv
// Directed, table-driven bench for factorial_divider with hand-written
// sequences for back-to-back, ignored-start and mid-operation reset.
module tb_factorial_divider;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic         busy;
    logic         done;
    logic [127:0] quotient;
    logic [63:0]  remainder;
    logic         div_by_zero;

    int passed;
    int total;

    typedef struct {
        logic [127:0] a;
        logic [63:0]  b;
        logic [127:0] q;
        logic [63:0]  r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs [9];

    factorial_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge. lat is the cycle in which done was seen
    // (cycle 0 = start presented), or limit if it never came.
    // mode 1: re-pulse start with 9/3 in cycle 40; mode 2: reset in cycle 60.
    task automatic run_op(input logic [127:0] a, input logic [63:0] b, input int mode,
                          input int limit, output int lat, output logic busy1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        busy1 = busy;
        while (!done && lat < limit) begin
            if (mode == 1 && lat == 40) begin
                start    = 1'b1;
                dividend = 128'd9;
                divisor  = 64'd3;
            end else if (mode == 1 && lat == 41) begin
                start = 1'b0;
            end
            if (mode == 2 && lat == 60) reset = 1'b1;
            else if (mode == 2 && lat == 61) reset = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        logic [127:0] f24;
        logic [127:0] f25;
        int           lat;
        logic         b1;

        passed   = 0;
        total    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 128'd0;
        divisor  = 64'd0;

        f24 = 128'd1;
        for (int i = 2; i <= 24; i++) f24 = f24 * 128'(i);
        f25 = f24 * 128'd25;

        vecs[0] = '{128'd120, 64'd5, 128'd24, 64'd0, 1'b0, 129};
        vecs[1] = '{{128{1'b1}}, {64{1'b1}}, {64'h1, 64'h1}, 64'd0, 1'b0, 129};
        vecs[2] = '{128'd3, {64{1'b1}}, 128'd0, 64'd3, 1'b0, 129};
        vecs[3] = '{128'h1234, 64'd0, {128{1'b1}}, 64'h1234, 1'b1, 1};
        vecs[4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'd1,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'd0, 1'b0, 129};
        vecs[5] = '{f25, 64'd25, f24, 64'd0, 1'b0, 129};
        vecs[6] = '{128'd1000007, 64'd1000, 128'd1000, 64'd7, 1'b0, 129};
        vecs[7] = '{{64'h1, 64'h0}, 64'h1_0000_0000, 128'h1_0000_0000, 64'd0, 1'b0, 129};
        vecs[8] = '{{64'h1, 64'h0}, 64'h8000_0000_0000_0001, 128'd1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 129};

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_quotient", quotient, 128'd0);
        check("rst_remainder", 128'(remainder), 128'd0);
        check("rst_dbz", 128'(div_by_zero), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].a, vecs[v].b, 0, 300, lat, b1);
            check($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
            check($sformatf("v%0d_busy_c1", v), 128'(b1), 128'(vecs[v].lat != 1));
            check($sformatf("v%0d_quotient", v), quotient, vecs[v].q);
            check($sformatf("v%0d_remainder", v), 128'(remainder), 128'(vecs[v].r));
            check($sformatf("v%0d_dbz", v), 128'(div_by_zero), 128'(vecs[v].dbz));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 128'(done), 128'd0);
        end

        // Back-to-back: new start presented in the done cycle.
        run_op(128'd100, 64'd7, 0, 300, lat, b1);
        check("b2b_latency", 128'(lat), 128'd129);
        check("b2b_quotient", quotient, 128'd14);
        check("b2b_remainder", 128'(remainder), 128'd2);
        dividend = 128'd25;
        divisor  = 64'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_dbz_done", 128'(done), 128'd1);
        check("b2b_dbz_flag", 128'(div_by_zero), 128'd1);
        check("b2b_dbz_quotient", quotient, {128{1'b1}});
        check("b2b_dbz_remainder", 128'(remainder), 128'd25);
        @(negedge clk);

        // start while busy must be ignored.
        run_op(f25, 64'd25, 1, 300, lat, b1);
        check("ign_latency", 128'(lat), 128'd129);
        check("ign_quotient", quotient, f24);
        check("ign_remainder", 128'(remainder), 128'd0);
        @(negedge clk);

        // Reset in the middle of CALC aborts with no done.
        run_op(128'd50, 64'd3, 2, 200, lat, b1);
        check("abort_no_done", 128'(lat), 128'd200);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_quotient", quotient, 128'd0);
        check("abort_remainder", 128'(remainder), 128'd0);
        check("abort_dbz", 128'(div_by_zero), 128'd0);
        run_op(128'd50, 64'd3, 0, 300, lat, b1);
        check("after_abort_latency", 128'(lat), 128'd129);
        check("after_abort_quotient", quotient, 128'd16);
        check("after_abort_remainder", 128'(remainder), 128'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
